// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 receiver bus: raw keyboard lines in, decoded scan code and status strobes out.
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] ps2_out;
  logic       ps2_key_pressed;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;

  modport master (output ps2_clk, ps2_dat,
                  input  ps2_out, ps2_key_pressed, parity_error, frame_error, rx_busy);
  modport slave  (input  ps2_clk, ps2_dat,
                  output ps2_out, ps2_key_pressed, parity_error, frame_error, rx_busy);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver: synchronise, glitch-filter the clock, shift 11-bit frames.
// Optional macro PS2_BREAK_FILTER_EN suppresses 0xF0 break codes and the byte that follows.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  ps2_keyboard_rx_if.slave    bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_out;
  logic          r_key, r_perr, r_ferr;

  logic w_clk_s, w_dat_s, w_edge, w_par_ok, w_stop_edge, w_good, w_timeout, w_deliver;

  assign w_clk_s     = r_clk_sync[1];
  assign w_dat_s     = r_dat_sync[1];
  // Edge event is the cycle in which the filtered clock is about to fall.
  assign w_edge      = r_filt & ~w_clk_s & (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_par_ok    = ^{r_shift, r_par};
  assign w_stop_edge = w_edge && (r_state == STOP);
  assign w_good      = w_stop_edge && w_dat_s && w_par_ok;
  assign w_timeout   = (r_state != IDLE) && !w_edge && (r_to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], bus.ps2_clk};
      r_dat_sync <= {r_dat_sync[0], bus.ps2_dat};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s != r_filt) begin
      if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end else begin
      r_filt_cnt <= '0;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic r_skip;
  // A byte after 0xF0 is the released key; swallow both, re-arm on any error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_skip <= 1'b0;
    else if (w_good)
      r_skip <= r_skip ? 1'b0 : (r_shift == 8'hF0);
    else if (w_stop_edge || w_timeout)
      r_skip <= 1'b0;
  end
  assign w_deliver = !r_skip && (r_shift != 8'hF0);
`else
  assign w_deliver = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_out     <= '0;
      r_key     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_key  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      if (r_state == IDLE) begin
        r_to_cnt <= '0;
        if (w_edge && !w_dat_s) begin
          r_state   <= DATA;
          r_bit_cnt <= '0;
          r_shift   <= '0;
        end
      end else if (w_edge) begin
        r_to_cnt <= '0;
        case (r_state)
          DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_dat_s;
            r_state <= STOP;
          end
          default: begin
            r_state <= IDLE;
            // Stop-bit error takes precedence so a frame is reported once.
            if (!w_dat_s)
              r_ferr <= 1'b1;
            else if (!w_par_ok)
              r_perr <= 1'b1;
            else if (w_deliver) begin
              r_out <= r_shift;
              r_key <= 1'b1;
            end
          end
        endcase
      end else if (w_timeout) begin
        r_state  <= IDLE;
        r_ferr   <= 1'b1;
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign bus.ps2_out         = r_out;
  assign bus.ps2_key_pressed = r_key;
  assign bus.parity_error    = r_perr;
  assign bus.frame_error     = r_ferr;
  assign bus.rx_busy         = (r_state != IDLE);
endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: clock cycles ps2_clk must stay stable before its filtered level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: idle clock cycles allowed between falling edges inside a frame.
REQ-003 Port clock, input, 1: single system clock; all state is on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port ps2_clk, input, 1: raw keyboard clock, asynchronous.
REQ-006 Port ps2_dat, input, 1: raw keyboard data, asynchronous.
REQ-007 Port ps2_out, output, 8: last accepted scan code, held until the next one is accepted.
REQ-008 Port ps2_key_pressed, output, 1: one-cycle strobe marking a new ps2_out value.
REQ-009 Port parity_error, output, 1: one-cycle strobe when a frame is discarded for bad parity.
REQ-010 Port frame_error, output, 1: one-cycle strobe when a frame is discarded for a bad stop bit or a timeout.
REQ-011 Port rx_busy, output, 1: high while the FSM is in any state other than IDLE.

Function
REQ-012 Synchronise ps2_clk and ps2_dat with two flops each before any use.
REQ-013 Filtered clock changes level only after the synchronised ps2_clk has held its new level for FILTER_LEN consecutive cycles.
REQ-014 A bit is sampled from synchronised ps2_dat in the cycle the filtered clock falls (the edge event).
REQ-015 FSM states and transitions:
- IDLE -> DATA on an edge event with data 0 (start bit).
- DATA -> PARITY after 8 data edges, received LSB first.
- PARITY -> STOP on the next edge.
- STOP -> IDLE on the next edge.
REQ-016 In IDLE, an edge event with data 1 is ignored and the FSM stays in IDLE.
REQ-017 Parity is odd: the 8 data bits plus the parity bit must contain an odd number of ones.
REQ-018 On the STOP edge, handling depends on the stop and parity bits; there is no double reporting.
- Stop 1 and parity good: in the next cycle, load ps2_out and pulse ps2_key_pressed.
- Stop 1 and parity bad: pulse parity_error only.
- Stop 0: pulse frame_error only, even if parity is also bad.
REQ-019 Latency: exactly one clock from the STOP edge event to any strobe.
REQ-020 A timeout counter is cleared on each edge event and counts in every non-IDLE state.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES, pulse frame_error, return to IDLE and discard any partial byte.
REQ-022 A rejected frame leaves ps2_out unchanged.
REQ-023 At most one of the three strobes is high in any cycle.
REQ-024 Back-to-back frames are accepted with no dead cycles beyond the filter delay.

Reset
REQ-025 While reset is low, all of the following hold, taking effect asynchronously:
- FSM in IDLE.
- ps2_out = 0x00.
- All strobes and rx_busy = 0.
- Filter, bit and timeout counters = 0.
- Synchronisers = 1.
REQ-026 Reset asserted mid-frame discards the frame; after release, reception resumes only from a fresh start bit.

Configuration
REQ-027 Macro PS2_BREAK_FILTER_EN controls suppression of break codes.
- Defined: a valid 0xF0 byte raises no strobe and arms a skip flag. The next valid byte clears the flag and raises no strobe; ps2_out keeps its previous value. A parity error, frame error or reset also clears the flag.
- Undefined: every valid byte, including 0xF0, is delivered with ps2_key_pressed.

Verification
REQ-028 Frame start 0, data 0x1C, parity 0, stop 1 -> single ps2_key_pressed pulse one cycle after the stop edge; ps2_out = 0x1C; no error strobes.
REQ-029 Same frame with parity 1 -> parity_error pulse; ps2_out keeps its prior value (0x00 after reset); no ps2_key_pressed.
REQ-030 Valid frames 0xF0 then 0x1C -> with PS2_BREAK_FILTER_EN: no ps2_key_pressed, ps2_out unchanged; without it: two pulses, ps2_out 0xF0 then 0x1C.
REQ-031 Five bits sent, then ps2_clk held high for TIMEOUT_CYCLES -> frame_error pulse and rx_busy drops; a following valid 0x29 frame is delivered correctly.
REQ-032 ps2_clk low glitch of FILTER_LEN-1 cycles in IDLE -> no state change, rx_busy stays 0; reset pulsed after bit 4 of a frame -> ps2_out = 0x00 and no strobe.
